// File: rtl/keypad_scan_pkg.sv
// Purpose: shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package keypad_scan_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    // Column lines are pulled up, so "no key" reads as all ones.
    localparam logic [KEY_COLS-1:0] COL_IDLE = 4'b1111;

    // All rows driven low at once, used whenever we are not stepping rows.
    localparam logic [KEY_ROWS-1:0] ROW_ALL = 4'b0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_SCAN,
        ST_HELD,
        ST_REL_DB
    } state_t;

    // Index of the lowest-numbered column that reads low.
    // Returns 0 when no column is low; callers only use it when one is.
    function automatic logic [1:0] lowest_low_col(input logic [KEY_COLS-1:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        for (int c = KEY_COLS - 1; c >= 0; c--) begin
            if (!col[c]) begin
                idx = 2'(c);
            end
        end
        return idx;
    endfunction

    // Active-low one-hot drive pattern selecting a single row.
    function automatic logic [KEY_ROWS-1:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Purpose: divides i_clk down to a single-cycle scan tick every DIV_NUM cycles.
// Latency: first tick DIV_NUM-1 cycles after reset release, then every DIV_NUM cycles.
// Backpressure: none; free-running.
module tick_gen #(
    parameter int DIV_NUM = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = (DIV_NUM > 1) ? $clog2(DIV_NUM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_NUM - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Tick is decoded from the terminal count so it lines up with the wrap.
    assign o_tick = (cnt == CNT_LAST);

    // Free-running 0..DIV_NUM-1 counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Purpose: debounced 4x4 matrix keypad scanner producing row*4+col key codes.
// Latency: DEBOUNCE_TICKS + 1..4 scan ticks after columns settle low, plus 2-cycle sync.
// Backpressure: none; o_key_valid is a one-cycle pulse that must be consumed when seen.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int F_CLK          = 50000000,
    parameter int F_SCAN         = 1000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_key_col,
    output logic [3:0] o_key_row,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_pressed
);

    localparam int DIV = F_CLK / F_SCAN;
    localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);

    // db_cnt is already 1 when a debounce state is entered, so the last
    // accepted count before the exit is DEBOUNCE_TICKS-1. Comparing against
    // that (rather than db_cnt+1) keeps the counter from ever wrapping.
    localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_TICKS - 1);

    logic [KEY_COLS-1:0] col_meta;
    logic [KEY_COLS-1:0] col_sync;
    logic                tick;
    state_t              state;
    logic [DBW-1:0]      db_cnt;
    logic [1:0]          row_idx;

    tick_gen #(
        .DIV_NUM (DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick)
    );

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_meta <= COL_IDLE;
            col_sync <= COL_IDLE;
        end else begin
            col_meta <= i_key_col;
            col_sync <= col_meta;
        end
    end

    // Debounce / scan FSM; moves only on scan ticks, valid pulse self-clears.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            db_cnt        <= '0;
            row_idx       <= 2'd0;
            o_key_row     <= ROW_ALL;
            o_key_code    <= 4'd0;
            o_key_valid   <= 1'b0;
            o_key_pressed <= 1'b0;
        end else begin
            o_key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (col_sync != COL_IDLE) begin
                            state  <= ST_PRESS_DB;
                            db_cnt <= DB_ONE;
                        end
                    end
                    ST_PRESS_DB: begin
                        if (col_sync == COL_IDLE) begin
                            state  <= ST_IDLE;
                            db_cnt <= '0;
                        end else if (db_cnt >= DB_LAST) begin
                            state     <= ST_SCAN;
                            db_cnt    <= '0;
                            row_idx   <= 2'd0;
                            o_key_row <= row_drive(2'd0);
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                        end
                    end
                    ST_SCAN: begin
                        if (col_sync != COL_IDLE) begin
                            // Rows are stepped from 0 upward, so the first hit
                            // is the lowest row; the column pick is lowest too.
                            state         <= ST_HELD;
                            o_key_code    <= {row_idx, lowest_low_col(col_sync)};
                            o_key_valid   <= 1'b1;
                            o_key_pressed <= 1'b1;
                            o_key_row     <= ROW_ALL;
                        end else if (row_idx == 2'd3) begin
                            // Key vanished before any row matched: a glitch.
                            state     <= ST_IDLE;
                            row_idx   <= 2'd0;
                            o_key_row <= ROW_ALL;
                        end else begin
                            row_idx   <= row_idx + 2'd1;
                            o_key_row <= row_drive(row_idx + 2'd1);
                        end
                    end
                    ST_HELD: begin
                        if (col_sync == COL_IDLE) begin
                            state  <= ST_REL_DB;
                            db_cnt <= DB_ONE;
                        end
                    end
                    ST_REL_DB: begin
                        if (col_sync != COL_IDLE) begin
                            state  <= ST_HELD;
                            db_cnt <= '0;
                        end else if (db_cnt >= DB_LAST) begin
                            state         <= ST_IDLE;
                            db_cnt        <= '0;
                            o_key_pressed <= 1'b0;
                        end else begin
                            db_cnt <= db_cnt + DB_ONE;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        db_cnt    <= '0;
                        o_key_row <= ROW_ALL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Purpose: self-checking bench for keypad_scan with a simulated key matrix.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scan;

    localparam int F_CLK  = 1000;
    localparam int F_SCAN = 100;
    localparam int DT     = 3;
    localparam int DIV    = F_CLK / F_SCAN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0000;   // bit r*4+c set = key at row r, column c held
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;

    int n_checks      = 0;
    int n_errors      = 0;
    int dut_valid_cnt = 0;

    // Expected outputs from the behavioural model.
    logic [3:0] exp_row     = 4'b0000;
    logic [3:0] exp_code    = 4'd0;
    logic       exp_valid   = 1'b0;
    logic       exp_pressed = 1'b0;

    // Model bookkeeping: runs of consecutive tick samples, scan position, hold flag.
    int m_div       = 0;
    int m_press_run = 0;
    int m_rel_run   = 0;
    int m_scan_row  = -1;           // -1 means not stepping rows
    bit m_held      = 1'b0;
    bit m_tick_edge = 1'b0;
    bit model_on    = 1'b0;

    always #5 clk = ~clk;

    // Passive matrix: a column reads low when a held key sits on a row driven low.
    function automatic logic [3:0] matrix_col(input logic [15:0] k, input logic [3:0] rows);
        logic [3:0] c;
        c = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (k[r*4+cc] && !rows[r]) c[cc] = 1'b0;
            end
        end
        return c;
    endfunction

    always_comb key_col = matrix_col(keys, key_row);

    keypad_scan #(
        .F_CLK          (F_CLK),
        .F_SCAN         (F_SCAN),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_col     (key_col),
        .o_key_row     (key_row),
        .o_key_code    (key_code),
        .o_key_valid   (key_valid),
        .o_key_pressed (key_pressed)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: advances on every clock edge, acts on scan ticks.
    // Keys only change right after a tick, so the column value seen at a tick
    // is the matrix evaluated against the rows currently driven.
    always @(posedge clk) begin
        logic [3:0] c;
        int low;
        if (rst) begin
            model_on    = 1'b1;
            m_div       = 0;
            m_press_run = 0;
            m_rel_run   = 0;
            m_scan_row  = -1;
            m_held      = 1'b0;
            m_tick_edge = 1'b0;
            exp_row     = 4'b0000;
            exp_code    = 4'd0;
            exp_valid   = 1'b0;
            exp_pressed = 1'b0;
        end else if (model_on) begin
            exp_valid   = 1'b0;
            m_tick_edge = (m_div == DIV - 1);
            m_div       = m_tick_edge ? 0 : m_div + 1;
            if (m_tick_edge) begin
                c = matrix_col(keys, exp_row);
                low = 0;
                for (int i = 3; i >= 0; i--) if (!c[i]) low = i;
                if (m_scan_row >= 0) begin
                    if (c != 4'b1111) begin
                        exp_code    = 4'(m_scan_row * 4 + low);
                        exp_valid   = 1'b1;
                        exp_pressed = 1'b1;
                        m_held      = 1'b1;
                        m_rel_run   = 0;
                        m_scan_row  = -1;
                        exp_row     = 4'b0000;
                    end else if (m_scan_row == 3) begin
                        m_scan_row = -1;
                        exp_row    = 4'b0000;
                    end else begin
                        m_scan_row = m_scan_row + 1;
                        exp_row    = ~(4'b0001 << m_scan_row);
                    end
                end else if (m_held) begin
                    if (c != 4'b1111) begin
                        m_rel_run = 0;
                    end else begin
                        m_rel_run = m_rel_run + 1;
                        if (m_rel_run == DT) begin
                            m_held      = 1'b0;
                            m_rel_run   = 0;
                            exp_pressed = 1'b0;
                        end
                    end
                end else begin
                    if (c != 4'b1111) begin
                        m_press_run = m_press_run + 1;
                        if (m_press_run == DT) begin
                            m_press_run = 0;
                            m_scan_row  = 0;
                            exp_row     = 4'b1110;
                        end
                    end else begin
                        m_press_run = 0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            check("row",     32'(key_row),     32'(exp_row));
            check("code",    32'(key_code),    32'(exp_code));
            check("valid",   32'(key_valid),   32'(exp_valid));
            check("pressed", 32'(key_pressed), 32'(exp_pressed));
            if (key_valid === 1'b1) dut_valid_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to just after the n-th upcoming tick edge, with a cycle budget.
    task automatic wait_ticks(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                step();
                guard++;
            end while (!m_tick_edge && guard < 2 * DIV);
            if (!m_tick_edge) begin
                n_checks++;
                n_errors++;
                $display("FAIL tick_wait: no tick within %0d cycles", 2 * DIV);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, %0d errors so far", n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        // Reset and idle.
        rst  = 1'b1;
        keys = 16'h0000;
        repeat (3) step();
        check("rst_row",     32'(key_row),     32'h0);
        check("rst_code",    32'(key_code),    32'h0);
        check("rst_valid",   32'(key_valid),   32'h0);
        check("rst_pressed", 32'(key_pressed), 32'h0);
        rst = 1'b0;
        repeat (100) step();
        check("idle_valid_cnt", 32'(dut_valid_cnt), 32'h0);
        check("idle_row",       32'(key_row),       32'h0);
        check("idle_pressed",   32'(key_pressed),   32'h0);

        // Row 2 / column 1: 3 debounce ticks, then rows 0,1,2 -> valid on tick 6.
        wait_ticks(1);
        base = dut_valid_cnt;
        keys = 16'h0200;
        wait_ticks(5);
        check("press_early", 32'(dut_valid_cnt - base), 32'h0);
        wait_ticks(1);
        check("press_valid_pulse", 32'(key_valid), 32'h1);
        check("press_code",        32'(key_code),  32'h9);
        step();
        check("press_one_valid", 32'(dut_valid_cnt - base), 32'h1);
        wait_ticks(14);
        check("held_one_valid", 32'(dut_valid_cnt - base), 32'h1);
        check("held_pressed",   32'(key_pressed),          32'h1);
        keys = 16'h0000;
        wait_ticks(2);
        check("release_pressed_2", 32'(key_pressed), 32'h1);
        wait_ticks(1);
        check("release_pressed_3", 32'(key_pressed), 32'h0);

        // Bounce: low 2 ticks, high 1 tick, never completes debounce.
        base = dut_valid_cnt;
        for (int i = 0; i < 3; i++) begin
            keys = 16'h0020;
            wait_ticks(2);
            keys = 16'h0000;
            wait_ticks(1);
        end
        wait_ticks(2);
        check("bounce_no_valid", 32'(dut_valid_cnt - base), 32'h0);
        check("bounce_row",      32'(key_row),              32'h0);

        // Key disappears once scanning starts: all four rows stepped, then idle.
        base = dut_valid_cnt;
        keys = 16'h1000;
        wait_ticks(3);
        check("glitch_scan_row0", 32'(key_row), 32'hE);
        keys = 16'h0000;
        wait_ticks(1);
        check("glitch_scan_row1", 32'(key_row), 32'hD);
        wait_ticks(3);
        check("glitch_idle_row", 32'(key_row),              32'h0);
        check("glitch_no_valid", 32'(dut_valid_cnt - base), 32'h0);

        // Two keys: row0/col3 wins over row1/col0.
        base = dut_valid_cnt;
        keys = 16'h0018;
        wait_ticks(4);
        check("multi_valid_pulse", 32'(key_valid), 32'h1);
        check("multi_code",        32'(key_code),  32'h3);
        wait_ticks(5);
        check("multi_one_valid", 32'(dut_valid_cnt - base), 32'h1);
        keys = 16'h0000;
        wait_ticks(4);
        check("multi_released", 32'(key_pressed), 32'h0);

        // Reset in the middle of a scan.
        base = dut_valid_cnt;
        keys = 16'h0200;
        wait_ticks(4);
        check("scan_row1", 32'(key_row), 32'hD);
        rst = 1'b1;
        step();
        check("scanrst_row",     32'(key_row),     32'h0);
        check("scanrst_code",    32'(key_code),    32'h0);
        check("scanrst_valid",   32'(key_valid),   32'h0);
        check("scanrst_pressed", 32'(key_pressed), 32'h0);
        rst  = 1'b0;
        keys = 16'h0000;
        repeat (30) step();
        check("scanrst_no_valid", 32'(dut_valid_cnt - base), 32'h0);

        // Release bounce while held: returns to held, no second valid.
        wait_ticks(1);
        base = dut_valid_cnt;
        keys = 16'h0004;
        wait_ticks(4);
        check("relb_code", 32'(key_code), 32'h2);
        keys = 16'h0000;
        wait_ticks(1);
        check("relb_pressed_rel", 32'(key_pressed), 32'h1);
        keys = 16'h0004;
        wait_ticks(4);
        check("relb_pressed_held", 32'(key_pressed),          32'h1);
        check("relb_one_valid",    32'(dut_valid_cnt - base), 32'h1);
        keys = 16'h0000;
        wait_ticks(3);
        check("relb_released", 32'(key_pressed), 32'h0);
        wait_ticks(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter F_CLK, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter F_SCAN, default 1000, scan tick frequency in Hz.
REQ-003 SHALL have parameter DEBOUNCE_TICKS, default 20, stable ticks required for press/release.
REQ-004 SHALL have port i_clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_key_col  input  4  keypad columns, active-low (pulled up), asynchronous.
REQ-007 SHALL have port o_key_row  output  4  keypad row drive, active-low.
REQ-008 SHALL have port o_key_code  output  4  last accepted key, row*4+col.
REQ-009 SHALL have port o_key_valid  output  1  one-cycle pulse, new o_key_code.
REQ-010 SHALL have port o_key_pressed  output  1  high while accepted key is held.

Function
REQ-011 SHALL pass i_key_col through a 2-flop synchronizer; all decisions use the synchronized value "col".
REQ-012 SHALL generate "tick" as a one-i_clk pulse every F_CLK/F_SCAN cycles: counter 0..DIV-1, tick when counter==DIV-1, then wrap to 0.
REQ-013 SHALL evaluate FSM transitions only in tick cycles, except reset and valid-pulse clearing.
REQ-014 SHALL implement states IDLE, PRESS_DB, SCAN, HELD, REL_DB.
REQ-015 IDLE: o_key_row=4'b0000; on tick with col!=4'b1111 -> PRESS_DB, db_cnt=1.
REQ-016 PRESS_DB: rows 4'b0000; on tick col==4'b1111 -> IDLE; else db_cnt+1; when db_cnt reaches DEBOUNCE_TICKS -> SCAN, row_idx=0.
REQ-017 SCAN: o_key_row=~(4'b0001<<row_idx); on tick with col!=4'b1111 -> HELD, capture code=row_idx*4+index of lowest-numbered low column; else row_idx+1.
REQ-018 SCAN with row_idx==3 and col==4'b1111 on tick SHALL -> IDLE, no valid pulse (glitch rejected).
REQ-019 Multiple simultaneous keys: lowest row, then lowest column wins; others ignored until full release.
REQ-020 HELD: rows 4'b0000, o_key_pressed=1; on tick col==4'b1111 -> REL_DB, db_cnt=1.
REQ-021 REL_DB: rows 4'b0000, o_key_pressed stays 1; on tick col!=4'b1111 -> HELD; else db_cnt+1; reaching DEBOUNCE_TICKS -> IDLE, o_key_pressed=0 on that transition.
REQ-022 o_key_valid SHALL be 1 for exactly the one i_clk cycle following the SCAN->HELD transition; o_key_code updates in that same cycle and holds until the next valid.
REQ-023 Held key SHALL produce exactly one valid pulse (no auto-repeat).
REQ-024 Press latency SHALL be DEBOUNCE_TICKS + 1..4 ticks after col stabilizes low, plus 2-cycle sync.

Reset
REQ-025 While i_rst=1 at a clock edge: state=IDLE, o_key_row=4'b0000, o_key_code=0, o_key_valid=0, o_key_pressed=0, tick counter=0, db_cnt=0, row_idx=0, synchronizer=4'b1111.
REQ-026 Reset asserted mid-debounce, mid-scan or while held SHALL abort without emitting o_key_valid.

Structure
REQ-027 Shared package SHALL hold the state enum, KEY_ROWS=4, KEY_COLS=4 and the active-low idle column constant 4'b1111.
REQ-028 Tick generation SHALL be a sub-module tick_gen (parameter DIV_NUM, ports i_clk, i_rst, o_tick).
REQ-029 Debounce counter width SHALL be $clog2(DEBOUNCE_TICKS+1); tick counter width $clog2(DIV).

Verification (F_CLK=1000, F_SCAN=100, DEBOUNCE_TICKS=3)
REQ-030 Reset, col=4'b1111 for 100 cycles -> rows 4'b0000, no valid, pressed=0.
REQ-031 Press row2/col1 (col low only when row2 driven) held 20 ticks -> single valid, code=4'd9, pressed high until 3 ticks after release.
REQ-032 Bounce: col low 2 ticks, high 1 tick, repeated -> no valid, FSM returns to IDLE.
REQ-033 Keys row0/col3 and row1/col0 together -> code=4'd3, one valid only.
REQ-034 Release bounce in HELD (high 1 tick, low again) -> back to HELD, no second valid, pressed stays 1.
REQ-035 i_rst pulsed during SCAN -> next cycle all outputs at reset values, no valid.
